// File: rtl/noise_filter_ctrl.sv
// ---------------------------------------------------------------------------
// noise_filter_ctrl
//
// Command/sequencing controller between the SPI receiver and the dynamic
// noise reduction filter. Decodes 16-bit command words ([15:12] opcode,
// [11:0] argument), owns the filter alpha register, streams samples into the
// filter, tracks in-flight samples across the fixed filter latency, and
// queues filter results and status words in an output FIFO toward spi_tx.
//
// Parameters:
//   FILT_LATENCY  cycles from o_filt_valid to a valid i_filt_y (1..8)
//   FIFO_DEPTH    output FIFO entries, power of two (2..16)
//
// Optional feature macro: NF_CTRL_ALPHA_CLAMP_EN
//   defined   : a negative alpha data word loads 0 and counts as an error
//   undefined : alpha data words are loaded verbatim
//
// Ports:
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_rx_data/i_rx_valid  word strobe from the SPI receiver
//   o_alpha               Q1.15 filter coefficient (reset 0x2000)
//   o_filt_x/o_filt_valid sample strobe to the filter
//   o_filt_clear          one-cycle filter state clear
//   i_filt_y              filter result, valid FILT_LATENCY after filt_valid
//   o_tx_data/o_tx_valid  FIFO head / FIFO not empty
//   i_tx_ready            transmitter takes the head this cycle
//   o_busy                state is not IDLE
//   o_dbg_state           0 IDLE, 1 ALPHA_WAIT, 2 STREAM, 3 DRAIN
//
// Handshake: the FIFO head is transferred in every cycle where
// o_tx_valid && i_tx_ready; o_tx_data is held stable while o_tx_valid is high
// and i_tx_ready is low. i_rx_valid is a strobe with no back-pressure.
// ---------------------------------------------------------------------------
module noise_filter_ctrl #(
   parameter int FILT_LATENCY = 2,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [15:0] i_rx_data,
   input  logic        i_rx_valid,
   output logic [15:0] o_alpha,
   output logic [15:0] o_filt_x,
   output logic        o_filt_valid,
   output logic        o_filt_clear,
   input  logic [15:0] i_filt_y,
   output logic [15:0] o_tx_data,
   output logic        o_tx_valid,
   input  logic        i_tx_ready,
   output logic        o_busy,
   output logic [1:0]  o_dbg_state
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_ALPHA_WAIT = 2'd1,
      S_STREAM     = 2'd2,
      S_DRAIN      = 2'd3
   } state_t;

   state_t                  r_state;
   state_t                  w_next;
   logic [15:0]             r_alpha;
   logic [15:0]             r_filt_x;
   logic                    r_filt_valid;
   logic                    r_filt_clear;
   logic [12:0]             r_remain;
   logic [FILT_LATENCY-1:0] r_sr;
   logic [FILT_LATENCY-1:0] w_sr_nxt;
   logic                    r_stat_pend;
   logic [15:0]             r_stat_word;
   logic                    r_ovf;
   logic [7:0]              r_err_cnt;
   logic [15:0]             r_mem [FIFO_DEPTH];
   logic [PW-1:0]           r_wptr;
   logic [PW-1:0]           r_rptr;
   logic [CW-1:0]           r_count;

   logic [3:0]              w_opcode;
   logic [11:0]             w_arg;
   logic                    w_ld_alpha;
   logic                    w_sample;
   logic                    w_ld_remain;
   logic                    w_stat_cap;
   logic                    w_clear;
   logic                    w_err_inc;
   logic                    w_busy;
   logic                    w_in_flight;
   logic                    w_full;
   logic                    w_pop;
   logic                    w_push_req;
   logic                    w_push;
   logic [15:0]             w_push_data;

   assign w_opcode    = i_rx_data[15:12];
   assign w_arg       = i_rx_data[11:0];
   // A sample is in flight from its filt_valid cycle until its capture cycle.
   assign w_in_flight = r_filt_valid || (r_sr != '0);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (i_rx_valid && w_opcode == 4'h1) w_next = S_ALPHA_WAIT;
            if (i_rx_valid && w_opcode == 4'h2) w_next = S_STREAM;
         end
         S_ALPHA_WAIT: if (i_rx_valid) w_next = S_IDLE;
         S_STREAM:     if (i_rx_valid && r_remain == 13'd1) w_next = S_DRAIN;
         S_DRAIN:      if (!w_in_flight) w_next = S_IDLE;
         default:      w_next = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs / datapath strobes ----------------
   always_comb begin
      w_ld_alpha  = 1'b0;
      w_sample    = 1'b0;
      w_ld_remain = 1'b0;
      w_stat_cap  = 1'b0;
      w_clear     = 1'b0;
      w_err_inc   = 1'b0;
      w_busy      = (r_state != S_IDLE);
      unique case (r_state)
         S_IDLE: if (i_rx_valid) begin
            unique case (w_opcode)
               4'h1:    ;
               4'h2:    w_ld_remain = 1'b1;
               4'h3:    w_stat_cap  = 1'b1;
               4'h4:    w_clear     = 1'b1;
               default: w_err_inc   = 1'b1;
            endcase
         end
         S_ALPHA_WAIT: w_ld_alpha = i_rx_valid;
         S_STREAM:     w_sample   = i_rx_valid;
         S_DRAIN:      w_err_inc  = i_rx_valid;
         default:      ;
      endcase
`ifdef NF_CTRL_ALPHA_CLAMP_EN
      if (w_ld_alpha && i_rx_data[15]) w_err_inc = 1'b1;
`endif
   end

   // Valid shift register: stage 0 follows filt_valid, the tail marks capture.
   always_comb begin
      w_sr_nxt[0] = r_filt_valid;
      for (int k = 1; k < FILT_LATENCY; k++) w_sr_nxt[k] = r_sr[k-1];
   end

   // ---------------- command / filter datapath ----------------
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_alpha      <= 16'h2000;
         r_filt_x     <= '0;
         r_filt_valid <= 1'b0;
         r_filt_clear <= 1'b0;
         r_remain     <= '0;
         r_sr         <= '0;
         r_stat_pend  <= 1'b0;
         r_stat_word  <= '0;
         r_ovf        <= 1'b0;
         r_err_cnt    <= '0;
      end else begin
         if (w_ld_alpha) begin
`ifdef NF_CTRL_ALPHA_CLAMP_EN
            r_alpha <= i_rx_data[15] ? 16'h0000 : i_rx_data;
`else
            r_alpha <= i_rx_data;
`endif
         end
         if (w_ld_remain)   r_remain <= (w_arg == 12'd0) ? 13'd4096 : {1'b0, w_arg};
         else if (w_sample) r_remain <= r_remain - 13'd1;
         if (w_sample) r_filt_x <= i_rx_data;
         r_filt_valid <= w_sample;
         r_filt_clear <= w_clear;
         r_sr         <= w_sr_nxt;
         // Status is snapshotted now and pushed next cycle, so it reaches the
         // FIFO head two cycles after the command.
         r_stat_pend  <= w_stat_cap;
         if (w_stat_cap) begin
            r_stat_word <= {r_ovf, w_busy, 5'(r_count), 1'b0, r_err_cnt};
            r_err_cnt   <= '0;
         end else if (w_err_inc && r_err_cnt != 8'hFF) begin
            r_err_cnt <= r_err_cnt + 8'd1;
         end
         // A drop in the same cycle as a capture must stay visible next time.
         if (w_stat_cap)             r_ovf <= 1'b0;
         if (w_push_req && !w_push)  r_ovf <= 1'b1;
      end
   end

   // ---------------- output FIFO ----------------
   // Captures and status pushes never coincide: a status is only captured in
   // IDLE, which is entered only once nothing is in flight.
   assign w_full      = (r_count == CW'(FIFO_DEPTH));
   assign o_tx_valid  = (r_count != '0);
   assign w_pop       = o_tx_valid && i_tx_ready;
   assign w_push_req  = r_sr[FILT_LATENCY-1] || r_stat_pend;
   assign w_push_data = r_sr[FILT_LATENCY-1] ? i_filt_y : r_stat_word;
   assign w_push      = w_push_req && (!w_full || w_pop);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop)  r_rptr <= r_rptr + PW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wptr] <= w_push_data;
   end

   assign o_tx_data    = o_tx_valid ? r_mem[r_rptr] : 16'h0000;
   assign o_alpha      = r_alpha;
   assign o_filt_x     = r_filt_x;
   assign o_filt_valid = r_filt_valid;
   assign o_filt_clear = r_filt_clear;
   assign o_busy       = w_busy;
   assign o_dbg_state  = r_state;

endmodule
